// File: rtl/tf_pkg.sv
// Shared definitions for the tanh feeder MAC: word widths, Q-format
// constants, FSM state encoding and the signed lane multiplier.
package tf_pkg;

    localparam int WORD_LEN_DEF = 38;
    localparam int NUM_IN_DEF   = 4;
    localparam int TAP_W_DEF    = 10;

    // Weight is Q2.13, state is Q0.15, so the raw product is Q3.28.
    // The accumulator word is Q9.28, so no shift is needed when adding.
    localparam int W_WIDTH    = 16;
    localparam int X_WIDTH    = 16;
    localparam int PROD_WIDTH = W_WIDTH + X_WIDTH;
    localparam int PROD_FRAC  = 28;

    // The pipeline is S1 -> S2 -> accumulator. After the last beat the
    // drain counter runs 0,1,2, and the result is presented while it reads 2.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2
    } tfState_e;

    // Full-precision signed 16x16 product. Both operands are sign-extended
    // to the product width, so the low PROD_WIDTH bits are exact.
    function automatic logic [PROD_WIDTH-1:0] mulQ(
        input logic [W_WIDTH-1:0] w,
        input logic [X_WIDTH-1:0] x
    );
        logic signed [PROD_WIDTH-1:0] wExt;
        logic signed [PROD_WIDTH-1:0] xExt;
        wExt = {{X_WIDTH{w[W_WIDTH-1]}}, w};
        xExt = {{W_WIDTH{x[X_WIDTH-1]}}, x};
        return wExt * xExt;
    endfunction

endpackage

// File: rtl/tf_mac_lane.sv
// One MAC lane: S1 captures weight and state, S2 holds the Q3.28 product,
// and S3 sign-extends the product and adds it into a wrapping Q9.28 accumulator.
module tf_mac_lane
    import tf_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic                clear_i,
    input  logic                beat_i,
    input  logic [W_WIDTH-1:0]  w_i,
    input  logic [X_WIDTH-1:0]  x_i,
    output logic [WORD_LEN-1:0] acc_o
);

    localparam int EXT_W = WORD_LEN - PROD_WIDTH;

    logic                  s1Valid_q, s1Valid_d;
    logic [W_WIDTH-1:0]    w_q, w_d;
    logic [X_WIDTH-1:0]    x_q, x_d;
    logic                  s2Valid_q, s2Valid_d;
    logic [PROD_WIDTH-1:0] prod_q, prod_d;
    logic [WORD_LEN-1:0]   acc_q, acc_d;
    logic [WORD_LEN-1:0]   prodExt;

    // Each stage loads only when a valid beat reaches it, so gaps in the
    // input stream leave the pipeline untouched. A start-time clear empties it.
    always_comb begin
        prodExt   = {{EXT_W{prod_q[PROD_WIDTH-1]}}, prod_q};
        s1Valid_d = beat_i;
        w_d       = beat_i ? w_i : w_q;
        x_d       = beat_i ? x_i : x_q;
        s2Valid_d = s1Valid_q;
        prod_d    = s1Valid_q ? mulQ(w_q, x_q) : prod_q;
        acc_d     = s2Valid_q ? (acc_q + prodExt) : acc_q;
        if (clear_i) begin
            s1Valid_d = 1'b0;
            s2Valid_d = 1'b0;
            acc_d     = '0;
        end
    end

    // Pipeline and accumulator registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            s1Valid_q <= 1'b0;
            w_q       <= '0;
            x_q       <= '0;
            s2Valid_q <= 1'b0;
            prod_q    <= '0;
            acc_q     <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            w_q       <= w_d;
            x_q       <= x_d;
            s2Valid_q <= s2Valid_d;
            prod_q    <= prod_d;
            acc_q     <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/tf_mac_acc.sv
// Top of the tanh feeder: the IDLE/ACC/DRAIN sequencer, the tap and drain
// counters and the beat handshake, driving NUM_IN parallel MAC lanes.
module tf_mac_acc
    import tf_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF,
    parameter int NUM_IN   = NUM_IN_DEF,
    parameter int TAP_W    = TAP_W_DEF
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       start,
    input  logic [TAP_W-1:0]           num_taps,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [X_WIDTH-1:0]         XIN,
    input  logic [W_WIDTH*NUM_IN-1:0]  WBUS,
    output logic [WORD_LEN*NUM_IN-1:0] OBUS,
    output logic                       out_valid,
    output logic                       busy
);

    tfState_e         state_q, state_d;
    logic [TAP_W-1:0] count_q, count_d;
    logic [TAP_W-1:0] numTaps_q, numTaps_d;
    logic [1:0]       drainCnt_q, drainCnt_d;
    logic             beat;
    logic             clearAcc;

    // Next-state logic and handshake outputs. start is looked at only in
    // IDLE, so a start during a run or in the out_valid cycle has no effect.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        numTaps_d  = numTaps_q;
        drainCnt_d = drainCnt_q;
        clearAcc   = 1'b0;
        beat       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    numTaps_d  = num_taps;
                    count_d    = '0;
                    drainCnt_d = '0;
                    clearAcc   = 1'b1;
                    state_d    = (num_taps != '0) ? ST_ACC : ST_DRAIN;
                end
            end
            ST_ACC: begin
                in_ready = (count_q < numTaps_q);
                beat     = in_valid && in_ready;
                if (beat) begin
                    count_d = count_q + TAP_W'(1);
                    if (count_d == numTaps_q) begin
                        drainCnt_d = '0;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drainCnt_q == DRAIN_LAST) begin
                    out_valid = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    drainCnt_d = drainCnt_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and counters, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            numTaps_q  <= '0;
            drainCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            numTaps_q  <= numTaps_d;
            drainCnt_q <= drainCnt_d;
        end
    end

    // Lane n takes its weight from WBUS slice n, shares the broadcast XIN
    // and drives OBUS slice n.
    for (genvar n = 0; n < NUM_IN; n++) begin : genLane
        tf_mac_lane #(
            .WORD_LEN (WORD_LEN)
        ) uLane (
            .clk     (clk),
            .clrn    (clrn),
            .clear_i (clearAcc),
            .beat_i  (beat),
            .w_i     (WBUS[W_WIDTH*n +: W_WIDTH]),
            .x_i     (XIN),
            .acc_o   (OBUS[WORD_LEN*n +: WORD_LEN])
        );
    end

endmodule

// File: tb/tb_tf_mac_acc.sv
// Directed bench for tf_mac_acc: a vector table of complete runs with
// hand-computed lane sums, plus reset, start-while-busy and hold sequences.
module tb_tf_mac_acc;

    localparam int WL = 38;
    localparam int NI = 4;
    localparam int TW = 10;
    localparam int NV = 7;

    logic              clk;
    logic              clrn;
    logic              start;
    logic [TW-1:0]     num_taps;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       XIN;
    logic [16*NI-1:0]  WBUS;
    logic [WL*NI-1:0]  OBUS;
    logic              out_valid;
    logic              busy;

    int checks;
    int failures;

    typedef struct packed {
        logic [TW-1:0]          numTaps;
        logic                   gapped;
        logic [NI-1:0][15:0]    w;
        logic [3:0][15:0]       xSeq;
        logic [NI-1:0][WL-1:0]  expObus;
    } vec_t;

    vec_t vecs [NV];

    tf_mac_acc #(
        .WORD_LEN (WL),
        .NUM_IN   (NI),
        .TAP_W    (TW)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .start     (start),
        .num_taps  (num_taps),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .XIN       (XIN),
        .WBUS      (WBUS),
        .OBUS      (OBUS),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WL-1:0] laneOf(input int n);
        return OBUS[WL*n +: WL];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Returns 1..8 for the negedge (counting the current one) at which
    // out_valid is seen, or 0 if it never appears within the budget.
    task automatic waitOutValid(output int lat);
        bit got;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            if (out_valid) begin
                got = 1'b1;
                lat = k;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic applyStimulus(input int v);
        int accepted;
        int cyc;
        int lat;
        bit phase;
        bit take;
        logic [TW-1:0] nt;
        nt = vecs[v].numTaps;
        @(negedge clk);
        start    = 1'b1;
        num_taps = nt;
        in_valid = 1'b1;
        XIN      = 16'h7FFF;
        WBUS     = '1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        num_taps = '0;
        accepted = 0;
        cyc      = 0;
        phase    = 1'b0;
        while (accepted < int'(nt) && cyc < 4000) begin
            in_valid = vecs[v].gapped ? !phase : 1'b1;
            XIN      = in_valid ? vecs[v].xSeq[accepted % 4] : 16'h5A5A;
            WBUS     = in_valid ? vecs[v].w : {NI{16'hA5A5}};
            take     = in_valid && in_ready;
            @(posedge clk);
            if (take) accepted++;
            @(negedge clk);
            phase = !phase;
            cyc++;
        end
        checkOutput($sformatf("v%0d beats accepted", v), 64'(accepted), 64'(nt));
        in_valid = 1'b1;
        XIN      = 16'h7FFF;
        WBUS     = {NI{16'h7FFF}};
        checkOutput($sformatf("v%0d in_ready after last beat", v), 64'(in_ready), 64'd0);
        waitOutValid(lat);
        checkOutput($sformatf("v%0d out_valid latency", v), 64'(lat), 64'd3);
        checkOutput($sformatf("v%0d busy at out_valid", v), 64'(busy), 64'd1);
        for (int n = 0; n < NI; n++) begin
            checkOutput($sformatf("v%0d lane%0d", v, n), 64'(laneOf(n)),
                        64'(vecs[v].expObus[n]));
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput($sformatf("v%0d out_valid single pulse", v), 64'(out_valid), 64'd0);
        checkOutput($sformatf("v%0d busy after done", v), 64'(busy), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        checks   = 0;
        failures = 0;
        clrn     = 1'b0;
        start    = 1'b0;
        num_taps = '0;
        in_valid = 1'b0;
        XIN      = '0;
        WBUS     = '0;

        // v0: single tap, X=0.5; lanes W = 1.0, -1.0, 0.5, 0
        vecs[0].numTaps = 10'd1;
        vecs[0].gapped  = 1'b0;
        vecs[0].w       = {16'h0000, 16'h1000, 16'hE000, 16'h2000};
        vecs[0].xSeq    = {4{16'h4000}};
        vecs[0].expObus = {38'h00_0000_0000, 38'h00_0400_0000,
                           38'h3F_F800_0000, 38'h00_0800_0000};
        // v1: 4 back-to-back taps, W=1.0, X=0x7FFF -> 4*0x0FFF_E000
        vecs[1].numTaps = 10'd4;
        vecs[1].gapped  = 1'b0;
        vecs[1].w       = {4{16'h2000}};
        vecs[1].xSeq    = {4{16'h7FFF}};
        vecs[1].expObus = {4{38'h00_3FFF_8000}};
        // v2: same run with gaps between beats
        vecs[2] = vecs[1];
        vecs[2].gapped = 1'b1;
        // v3: mixed signs, 2 taps, X=0.5; lanes W = -4.0, max, -1.0, 1.0
        vecs[3].numTaps = 10'd2;
        vecs[3].gapped  = 1'b0;
        vecs[3].w       = {16'h2000, 16'hE000, 16'h7FFF, 16'h8000};
        vecs[3].xSeq    = {4{16'h4000}};
        vecs[3].expObus = {38'h00_1000_0000, 38'h3F_F000_0000,
                           38'h00_3FFF_8000, 38'h3F_C000_0000};
        // v4: varying X = 0.5, -0.5, 0.25 (sum 0.25)
        vecs[4].numTaps = 10'd3;
        vecs[4].gapped  = 1'b1;
        vecs[4].w       = {16'h0000, 16'h7FFF, 16'hE000, 16'h2000};
        vecs[4].xSeq    = {16'h0000, 16'h2000, 16'hC000, 16'h4000};
        vecs[4].expObus = {38'h00_0000_0000, 38'h00_0FFF_E000,
                           38'h3F_FC00_0000, 38'h00_0400_0000};
        // v5: zero taps right after a non-zero run -> cleared result
        vecs[5].numTaps = 10'd0;
        vecs[5].gapped  = 1'b0;
        vecs[5].w       = {4{16'h7FFF}};
        vecs[5].xSeq    = {4{16'h7FFF}};
        vecs[5].expObus = '0;
        // v6: 1023 taps of 0x8000*0x8000 = 2^30 -> (2^40 - 2^30) mod 2^38
        vecs[6].numTaps = 10'd1023;
        vecs[6].gapped  = 1'b0;
        vecs[6].w       = {4{16'h8000}};
        vecs[6].xSeq    = {4{16'h8000}};
        vecs[6].expObus = {4{38'h3F_C000_0000}};

        // Reset values, sampled while reset is still held
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset OBUS", 64'(OBUS != '0), 64'd0);
        @(negedge clk);
        clrn = 1'b1;

        // Reset in the middle of an 8-tap run after 3 beats
        @(negedge clk);
        start    = 1'b1;
        num_taps = 10'd8;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        XIN      = 16'h4000;
        WBUS     = {NI{16'h2000}};
        repeat (3) @(negedge clk);
        checkOutput("midrun lane0 before reset", 64'(laneOf(0)), 64'h0800_0000);
        checkOutput("midrun busy before reset", 64'(busy), 64'd1);
        clrn     = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        checkOutput("midrun OBUS after reset", 64'(OBUS != '0), 64'd0);
        checkOutput("midrun busy after reset", 64'(busy), 64'd0);
        checkOutput("midrun in_ready after reset", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        checkOutput("midrun no pipeline leak", 64'(OBUS != '0), 64'd0);

        for (int v = 0; v < NV; v++) begin
            applyStimulus(v);
        end

        // start held high through a 2-tap run, including the out_valid cycle
        @(negedge clk);
        start    = 1'b1;
        num_taps = 10'd2;
        @(negedge clk);
        num_taps = 10'd5;
        in_valid = 1'b1;
        XIN      = 16'h4000;
        WBUS     = {NI{16'h2000}};
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        waitOutValid(lat);
        checkOutput("busystart latency", 64'(lat), 64'd3);
        checkOutput("busystart lane0", 64'(laneOf(0)), 64'h1000_0000);
        checkOutput("busystart lane3", 64'(laneOf(3)), 64'h1000_0000);
        @(negedge clk);
        start = 1'b0;
        checkOutput("coincident start ignored", 64'(busy), 64'd0);
        checkOutput("coincident out_valid low", 64'(out_valid), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("hold lane0", 64'(laneOf(0)), 64'h1000_0000);
        checkOutput("hold lane2", 64'(laneOf(2)), 64'h1000_0000);
        start    = 1'b1;
        num_taps = 10'd0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("restart clears OBUS", 64'(OBUS != '0), 64'd0);
        checkOutput("restart busy", 64'(busy), 64'd1);
        waitOutValid(lat);
        checkOutput("restart zero-tap latency", 64'(lat), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
